mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width of all ports.
REQ-002 Parameter ADDR_WIDTH, default 6 (64-word data memory), SHALL set the word address width.
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be asynchronous, active-high.
REQ-005 Ports req0/req1  input  1  SHALL be the access requests: port 0 = CPU, port 1 = loader/debug.
REQ-006 Ports we0/we1  input  1  SHALL select write (1) or read (0) per port.
REQ-007 Ports addr0/addr1 (ADDR_WIDTH) and wdata0/wdata1 (DATA_WIDTH), inputs, SHALL carry the request address and write data.
REQ-008 Ports gnt0/gnt1  output  1  SHALL each pulse high for one cycle when that port's request issues to memory.
REQ-009 Ports rvalid0/rvalid1 (output 1) and rdata0/rdata1 (output DATA_WIDTH) SHALL return read data.
REQ-010 Ports mem_en, mem_we (output 1), mem_addr (ADDR_WIDTH), mem_wdata (DATA_WIDTH) SHALL drive the memory; mem_rdata (input DATA_WIDTH) SHALL be valid one cycle after a read issue.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and READ_WAIT.
REQ-012 In IDLE with at least one reqN high, the arbiter SHALL issue exactly one request that cycle: mem_en=1, mem_we/addr/wdata copied from the winner, gntN=1 for the winner only.
REQ-013 An issued write SHALL complete in the issue cycle; the FSM SHALL remain in IDLE.
REQ-014 An issued read SHALL move the FSM to READ_WAIT; in READ_WAIT, mem_en=0, no gnt is asserted, rvalidN=1 for the owning port, rdataN=mem_rdata, and the next state is IDLE.
REQ-015 Read latency from gnt to rvalid SHALL be exactly 1 cycle; maximum throughput is one write per cycle or one read per 2 cycles.
REQ-016 A requester SHALL hold req, we, addr and wdata stable until it samples gnt high; the arbiter SHALL NOT latch un-granted requests.
REQ-017 With no req high in IDLE, all outputs other than rdataN SHALL be 0.
REQ-018 rdataN SHALL be 0 whenever rvalidN is 0.
REQ-019 A request deasserted before gnt SHALL be dropped without any memory access.
REQ-020 An 8-bit saturating counter per port (gnt_cnt0, gnt_cnt1, internal, observable hierarchically) SHALL increment on every gnt and stop at 255.

Reset
REQ-021 Asserting reset SHALL immediately force state=IDLE; all gnt, rvalid, mem_en and mem_we outputs = 0; rdata = 0; gnt counters = 0; last-winner = port 1.
REQ-022 Reset asserted while in READ_WAIT SHALL discard the pending read; no rvalid SHALL follow deassertion.
REQ-023 The first rising edge after reset deassertion SHALL be able to issue a request.

Configuration
REQ-024 With macro MEM_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the port that did not win most recently (last-winner register updated on every issue).
REQ-025 Without MEM_ARBITER_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to port 0 (fixed priority); the last-winner register SHALL not exist.

Verification
REQ-026 Reset, then req0=1 we0=1 addr0=5 wdata0=0xDEADBEEF for 1 cycle -> gnt0=1, mem_en=1, mem_we=1, mem_addr=5 the same cycle; FSM stays IDLE.
REQ-027 Memory holds 0x12345678 at addr 9; req1=1 we1=0 addr1=9 -> gnt1 cycle N, rvalid1=1 and rdata1=0x12345678 cycle N+1, no gnt in cycle N+1.
REQ-028 req0 and req1 held high, both writes, with ROUND_ROBIN_EN -> grant sequence 0,1,0,1 on consecutive cycles after reset; without it -> gnt0 every cycle, gnt1 never.
REQ-029 req0 read issued, reset asserted mid-cycle during READ_WAIT -> all outputs 0 immediately, no rvalid0 after reset release.
REQ-030 req0 continuous writes for 300 cycles -> gnt_cnt0 saturates at 255, gnt_cnt1=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: CPU (port 0) and loader/debug (port 1). Writes take one cycle, reads take two.
// Define MEM_ARBITER_ROUND_ROBIN_EN for alternating grants under contention; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       win1;
  logic [7:0] gnt_cnt0, gnt_cnt1;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_win;

  // Under contention port 1 wins only if port 0 won last.
  always_comb win1 = req1 & (~req0 | ~last_win);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_win <= 1'b1;
    else if (gnt0 | gnt1)
      last_win <= gnt1;
  end
`else
  always_comb win1 = req1 & ~req0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      gnt_cnt0 <= 8'd0;
      gnt_cnt1 <= 8'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (gnt0 && gnt_cnt0 != 8'hFF) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (gnt1 && gnt_cnt1 != 8'hFF) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end

  // Outputs are gated by reset so an asserted reset silences the bus at once.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state == IDLE) begin
        if (req0 | req1) begin
          gnt0      = ~win1;
          gnt1      = win1;
          mem_en    = 1'b1;
          mem_we    = win1 ? we1 : we0;
          mem_addr  = win1 ? addr1 : addr0;
          mem_wdata = win1 ? wdata1 : wdata0;
          if (!(win1 ? we1 : we0)) begin
            state_nxt = READ_WAIT;
            owner_nxt = win1;
          end
        end
      end else begin
        rvalid0   = ~owner;
        rvalid1   = owner;
        rdata0    = owner ? '0 : mem_rdata;
        rdata1    = owner ? mem_rdata : '0;
        state_nxt = IDLE;
      end
    end
  end

endmodule
